uart_ram_loader: RTL
====================

// Module: uart_ram_loader
// PURPOSE
//  8N1 serial receiver plus word assembler that streams a host-sent image into RAM port 2
//  (wEn2/addr2/dataIn2) while the CPU keeps port 1.
//  Sits between the FPGA serialIn pin and ProcMem. MemoryMap supplies the load start
//  address; the last received byte is exported for MemoryMap polling.
//  Runs on the raw board clock (clk), not the divided CPU clock.
// PARAMETERS
//  CLK_HZ        100_000_000  board clock frequency
//  BAUD          115_200      serial bit rate; DIV = CLK_HZ/BAUD clk cycles per bit (integer divide)
//  ADDR_WIDTH    12           RAM word-address width
//  TIMEOUT_BITS  40           idle bit-times after which a partial word is discarded
// PORTS
//  clk         in   1           board clock; all logic on posedge
//  rst         in   1           asynchronous, active-low reset
//  serialIn    in   1           UART RX line, idle high, asynchronous to clk
//  setAddr     in   1           one-cycle strobe: load startAddr as next write address
//  startAddr   in   ADDR_WIDTH  word address captured on setAddr
//  writeEnable out  1           one-cycle RAM port-2 write strobe
//  writeAddr   out  ADDR_WIDTH  RAM port-2 word address, valid with writeEnable
//  writeData   out  32          assembled word, valid with writeEnable
//  lastByte    out  8           most recently received good byte
//  byteValid   out  1           one-cycle pulse when lastByte updates
//  busy        out  1           high while the RX FSM is not IDLE or a partial word is held
//  err         out  1           sticky: framing error or partial-word timeout
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, next address 0, byte index 0, FSM IDLE,
//   synchronizer flops preset to 1.
//  serialIn passes through a 2-flop synchronizer before any use; FSM latency counts from the
//   synchronized signal.
//  RX FSM:
//   IDLE  -> START on synced line low.
//   START: wait DIV/2 cycles, resample. Low -> DATA; high -> IDLE (glitch, no error).
//   DATA:  sample every DIV cycles, 8 bits LSB first -> STOP.
//   STOP:  sample after DIV cycles.
//          High: lastByte <= byte, byteValid pulses 1 cycle, byte goes to assembler.
//          Low: err <= 1, byte dropped.
//          Either way -> IDLE. No wait for the line to return high beyond the IDLE low-detect.
//  Assembler: little-endian. Byte k (k = 0..3) goes to writeData[8k+7:8k].
//   On byte 3: cycle after byteValid, writeEnable = 1 for exactly 1 cycle, with
//    writeAddr = current address and writeData = the full word.
//   Following cycle: address += 1, mod 2^ADDR_WIDTH (0xFFF -> 0x000), byte index <= 0.
//   writeData and writeAddr hold their values between strobes.
//  setAddr: address <= startAddr, byte index <= 0 (partial word discarded), err <= 0.
//   - Takes effect the next cycle.
//   - Wins over a same-cycle byte completion; that byte is not assembled but still
//     updates lastByte.
//   - Does not disturb an in-flight RX FSM.
//  Timeout: counter runs only while byte index != 0 and FSM is IDLE; cleared on each good byte.
//   At TIMEOUT_BITS*DIV cycles: byte index <= 0, err <= 1, no write.
//  err clears only on setAddr or reset.
//  busy = (FSM != IDLE) | (byte index != 0).
// TESTING  (CLK_HZ=1_600_000, BAUD=100_000 -> DIV=16)
//  setAddr with startAddr=0x010, then send bytes 78 56 34 12 -> one writeEnable,
//   writeAddr=0x010, writeData=0x12345678; byteValid pulses 4 times; err=0.
//  Send 8 bytes after setAddr 0xFFF -> writes at 0xFFF then 0x000 (wrap); lastByte=final byte.
//  4-cycle low glitch on serialIn -> FSM returns IDLE; no byteValid, no err.
//  Byte with stop bit 0 -> err=1, lastByte unchanged; setAddr clears err.
//  Send 2 bytes, then idle 40*16 cycles -> err=1, no write; next 4 bytes write at the
//   unchanged address.
//  Assert rst mid-byte -> all outputs 0 immediately; next clean byte is received correctly.

Source files
------------

// File: rtl/uart_ram_loader.sv
// 8N1 UART receiver plus little-endian word assembler that streams a host image into RAM port 2.
// Runs on the raw board clock; the last good byte is exported for memory-mapped polling.
module uart_ram_loader #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serialIn,
    input  logic                  setAddr,
    input  logic [ADDR_WIDTH-1:0] startAddr,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddr,
    output logic [31:0]           writeData,
    output logic [7:0]            lastByte,
    output logic                  byteValid,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned DIV       = CLK_HZ / BAUD;
    localparam int unsigned HALF      = DIV / 2;
    localparam int unsigned CNT_W     = $clog2(DIV + 1);
    localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * DIV;
    localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic             rx;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             asm_valid;
    logic             frame_err;
    logic             fsm_idle;

    logic [1:0]            idx;
    logic [23:0]           word_buf;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TMO_W-1:0]      tmo;

    // Two-flop synchronizer; idle-high preset keeps reset from looking like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serialIn};
        end
    end

    assign rx       = sync_q[1];
    assign fsm_idle = (state == ST_IDLE);

    // RX state machine: mid-bit sampling, LSB first, single stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            lastByte  <= '0;
            byteValid <= 1'b0;
            asm_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byteValid <= 1'b0;
            asm_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == CNT_W'(HALF - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt     <= '0;
                        shift   <= {rx, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt == CNT_W'(DIV - 1)) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rx) begin
                            lastByte  <= shift;
                            byteValid <= 1'b1;
                            // A same-cycle setAddr discards this byte from the word
                            asm_valid <= ~setAddr;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Word assembler, write strobe, address counter, partial-word timeout and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx         <= '0;
            word_buf    <= '0;
            addr        <= '0;
            tmo         <= '0;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            writeEnable <= 1'b0;
            busy        <= ~fsm_idle | (idx != 2'd0);
            if (setAddr) begin
                addr <= startAddr;
                idx  <= '0;
                tmo  <= '0;
                err  <= 1'b0;
            end else begin
                if (writeEnable) begin
                    addr <= addr + ADDR_WIDTH'(1);
                    idx  <= '0;
                    tmo  <= '0;
                end else if (asm_valid) begin
                    tmo <= '0;
                    case (idx)
                        2'd0: word_buf[7:0]   <= lastByte;
                        2'd1: word_buf[15:8]  <= lastByte;
                        2'd2: word_buf[23:16] <= lastByte;
                        default: begin
                            writeEnable <= 1'b1;
                            writeAddr   <= addr;
                            writeData   <= {lastByte, word_buf};
                        end
                    endcase
                    if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                    end
                end else if ((idx != 2'd0) && fsm_idle) begin
                    if (tmo == TMO_W'(TMO_LIMIT - 1)) begin
                        tmo <= '0;
                        idx <= '0;
                        err <= 1'b1;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                if (frame_err) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
